// File: rtl/button_pkg.sv
// button_pkg: shared types and constants for the button conditioner.
//   btn_state_e   - per-button debounce FSM state (2-bit enum)
//   BTN_*         - bit positions of the user buttons in btn_raw / btn_*
//   cnt_width()   - width of a counter that must hold values 0 .. max_val-1
package button_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } btn_state_e;

    localparam int unsigned BTN_SET_CLOCK = 0;
    localparam int unsigned BTN_SET_ALARM = 1;
    localparam int unsigned BTN_MIN       = 2;
    localparam int unsigned BTN_HR        = 3;
    localparam int unsigned BTN_ALARM_OFF = 4;

    // Counters only ever reach max_val-1 before they restart or stop.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// btn_debounce_fsm: one button channel - 2-FF synchroniser, polarity
// normalisation, debounce FSM and (optionally) auto-repeat.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   pad        raw asynchronous pad input
//   level      registered debounced level, 1 = pressed
//   pulse      one-cycle pulse on accepted press and on each repeat
//   long_press 1 while held past the first repeat
// Macro BUTTON_AUTO_REPEAT_EN builds the repeat counter for channels with
// REPEAT_EN=1; without it pulse fires only on press and long_press is 0.
//
// state          | meaning
// ---------------+---------------------------------------------------
// ST_RELEASED    | stable released, level=0
// ST_DEB_PRESS   | candidate press, counting stable pressed samples
// ST_PRESSED     | stable pressed, level=1
// ST_DEB_RELEASE | candidate release, counting, level still 1
module btn_debounce_fsm
    import button_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 25000,
    parameter int unsigned REPEAT_DELAY    = 2500000,
    parameter int unsigned REPEAT_PERIOD   = 1000000,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned CNT_W           = 22
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic level,
    output logic pulse,
    output logic long_press
);

    localparam logic             IDLE_PAD = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce_fsm: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_EN && (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2)) begin : g_bad_repeat
        $error("btn_debounce_fsm: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
    end

    logic [1:0]       sync_q;
    logic             s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d;
    logic             press_d;
    logic             rep_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= {2{IDLE_PAD}};
        else        sync_q <= {sync_q[0], pad};
    end

    assign s = sync_q[1] ^ ACTIVE_LOW;

    // cnt only advances while below DEB_LAST, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            ST_RELEASED: begin
                if (s) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_DEB_RELEASE: begin
                if (s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == ST_PRESSED) || (state_d == ST_DEB_RELEASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            pulse   <= press_d | rep_fire;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    if (REPEAT_EN) begin : g_repeat
        localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
        localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

        logic [CNT_W-1:0] rcnt_q;
        logic             long_q;

        // Before the first repeat the target is the initial delay; after it
        // (long_q set) the shorter period applies.
        assign rep_fire = level && (rcnt_q == (long_q ? PERIOD_LAST : DELAY_LAST));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rcnt_q <= '0;
                long_q <= 1'b0;
            end else begin
                if (!level || rep_fire) rcnt_q <= '0;
                else                    rcnt_q <= rcnt_q + 1'b1;
                long_q <= level_d && (long_q || rep_fire);
            end
        end

        assign long_press = long_q;
    end else begin : g_no_repeat
        assign rep_fire   = 1'b0;
        assign long_press = 1'b0;
    end
`else
    assign rep_fire   = 1'b0;
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects the clock /
// alarm user buttons (bit 0 Set_Clock, 1 Set_Alarm, 2 MIN, 3 HR, 4 Alarm_Off).
// Ports:
//   clk        undivided system clock
//   reset      asynchronous, active-low reset
//   btn_raw    raw pad inputs
//   btn_level  registered debounced level, 1 = pressed
//   btn_pulse  one-cycle pulse per accepted press and per auto-repeat
//   btn_long   1 while held past the repeat delay
// Macro BUTTON_AUTO_REPEAT_EN enables auto-repeat on REPEAT_MASK bits.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned      N_BTN           = 5,
    parameter bit               ACTIVE_LOW      = 1'b1,
    parameter int unsigned      DEBOUNCE_CYCLES = 25000,
    parameter int unsigned      REPEAT_DELAY    = 2500000,
    parameter int unsigned      REPEAT_PERIOD   = 1000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b01100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_long
);

    localparam int unsigned MAX_A =
        (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CNT =
        (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int unsigned CNT_W = cnt_width(MAX_CNT);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce_fsm #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i]),
            .CNT_W           (CNT_W)
        ) u_fsm (
            .clk        (clk),
            .reset      (reset),
            .pad        (btn_raw[i]),
            .level      (btn_level[i]),
            .pulse      (btn_pulse[i]),
            .long_press (btn_long[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5, ACTIVE_LOW=1. Expected pulses are queued
// as (cycle, vector) when stimulus is applied; a monitor pops one entry for
// every cycle the DUT shows a nonzero btn_pulse.
module tb_button_conditioner;
    import button_pkg::*;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic [4:0] btn_long;

    button_conditioner #(
        .N_BTN           (5),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5),
        .REPEAT_MASK     (5'b01100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .btn_long  (btn_long)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [4:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic expect_pulse(input int at, input logic [4:0] vec);
        exp_t e;
        e.at  = at;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor
    always @(negedge clk) begin
        if (btn_pulse != 5'b0) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pulse_unexpected: got %b at cycle %0d, expected none", btn_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.at != cyc || e.vec != btn_pulse) begin
                    miscompares++;
                    $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d",
                             btn_pulse, cyc, e.vec, e.at);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int n;
    int r;
    logic [6:0] bounce_pat;

    initial begin
        reset   = 1'b0;
        btn_raw = 5'b11111;
        step(2);
        check("rst_level", btn_level, 0);
        check("rst_pulse", btn_pulse, 0);
        check("rst_long",  btn_long,  0);
        reset = 1'b1;
        step(3);

        // Clean press on MIN, 2-cycle release blip, then a real release
        n = cyc;
        btn_raw[BTN_MIN] = 1'b0;
        expect_pulse(n + 7, 5'b00100);
        if (REP) expect_pulse(n + 17, 5'b00100);
        step(6);
        check("press_level_early", btn_level[BTN_MIN], 0);
        step(1);
        check("press_level", btn_level, 5'b00100);
        step(1);
        btn_raw[BTN_MIN] = 1'b1;
        step(2);
        btn_raw[BTN_MIN] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("glitch_level", btn_level[BTN_MIN], 1);
        end
        btn_raw[BTN_MIN] = 1'b1;
        step(6);
        check("release_level_early", btn_level[BTN_MIN], 1);
        step(1);
        check("release_level", btn_level[BTN_MIN], 0);
        step(5);

        // Bounce on Set_Clock: low 3, high 1, low 3, then high
        bounce_pat = 7'b0001000;
        for (int k = 0; k < 17; k++) begin
            btn_raw[BTN_SET_CLOCK] = (k < 7) ? bounce_pat[6-k] : 1'b1;
            step(1);
            check("bounce_level", btn_level[BTN_SET_CLOCK], 0);
        end

        // Auto-repeat on HR, held 38 cycles
        n = cyc;
        btn_raw[BTN_HR] = 1'b0;
        expect_pulse(n + 7, 5'b01000);
        if (REP) begin
            for (int k = 0; k < 6; k++) expect_pulse(n + 17 + 5 * k, 5'b01000);
        end
        step(16);
        check("hr_long_early", btn_long[BTN_HR], 0);
        step(1);
        check("hr_long_first", btn_long[BTN_HR], REP);
        step(21);
        btn_raw[BTN_HR] = 1'b1;
        step(6);
        check("hr_long_held", btn_long[BTN_HR], REP);
        check("hr_level_held", btn_level[BTN_HR], 1);
        step(1);
        check("hr_long_clear", btn_long[BTN_HR], 0);
        check("hr_level_clear", btn_level[BTN_HR], 0);
        step(5);

        // Non-repeat button Alarm_Off held 38 cycles
        n = cyc;
        btn_raw[BTN_ALARM_OFF] = 1'b0;
        expect_pulse(n + 7, 5'b10000);
        step(30);
        check("aoff_level", btn_level[BTN_ALARM_OFF], 1);
        check("aoff_long", btn_long[BTN_ALARM_OFF], 0);
        step(8);
        btn_raw[BTN_ALARM_OFF] = 1'b1;
        step(12);

        // Simultaneous press of Set_Clock and Set_Alarm
        n = cyc;
        btn_raw[BTN_SET_ALARM] = 1'b0;
        btn_raw[BTN_SET_CLOCK] = 1'b0;
        expect_pulse(n + 7, 5'b00011);
        step(7);
        check("simul_level", btn_level, 5'b00011);
        step(3);
        btn_raw = 5'b11111;
        step(12);

        // Reset mid-press on MIN
        n = cyc;
        btn_raw[BTN_MIN] = 1'b0;
        expect_pulse(n + 7, 5'b00100);
        step(8);
        check("midrst_level_before", btn_level[BTN_MIN], 1);
        reset = 1'b0;
        #1;
        check("midrst_level", btn_level, 0);
        check("midrst_pulse", btn_pulse, 0);
        check("midrst_long",  btn_long,  0);
        step(2);
        reset = 1'b1;
        r = cyc;
        expect_pulse(r + 7, 5'b00100);
        step(6);
        check("repress_level_early", btn_level[BTN_MIN], 0);
        step(1);
        check("repress_level", btn_level[BTN_MIN], 1);
        step(1);
        btn_raw[BTN_MIN] = 1'b1;
        step(15);

        check("pending_pulses", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
